// File: rtl/ray_object_scheduler.sv
// Ray/object scheduler: streams the scene's objects through a combinational
// sphere unit for one ray at a time, keeps the nearest hit, and hands the
// result downstream through a valid/ready handshake.
module ray_object_scheduler #(
   parameter int          ADDR_W   = 6,
   parameter int          MAX_OBJ  = 64,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ray_valid,
   output logic              ray_ready,
   input  logic [27:0]       ray_init,
   input  logic [27:0]       ray_dir,
   input  logic [ADDR_W:0]   num_objects,
   output logic [ADDR_W-1:0] obj_addr,
   input  logic [49:0]       obj_data,
   output logic [27:0]       sph_init,
   output logic [27:0]       sph_dir,
   output logic [49:0]       sph_object,
   input  logic [9:0]        sph_t,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_hit,
   output logic [9:0]        res_t,
   output logic [11:0]       res_color,
   output logic [ADDR_W-1:0] res_index
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(MAX_OBJ);

   state_t              state_reg, state_next;
   logic [27:0]         init_reg, dir_reg;
   logic [ADDR_W:0]     n_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic                d1_reg;
   logic [9:0]          best_t_reg;
   logic [11:0]         best_color_reg;
   logic [ADDR_W-1:0]   best_index_reg;
   logic                hit_reg;
   logic                res_valid_reg, res_hit_reg;
   logic [9:0]          res_t_reg;
   logic [11:0]         res_color_reg;
   logic [ADDR_W-1:0]   res_index_reg;

   logic                accept;
   logic [ADDR_W:0]     n_clamp;
   logic [ADDR_W:0]     n_m1;
   logic                last_addr;
   logic                cmp_en;
   logic                cand;
   logic [ADDR_W-1:0]   cmp_idx;

   assign ray_ready  = (state_reg == IDLE);
   assign accept     = ray_valid && ray_ready;
   assign obj_addr   = addr_reg;
   assign sph_init   = init_reg;
   assign sph_dir    = dir_reg;
   assign sph_object = obj_data;
   assign res_valid  = res_valid_reg;
   assign res_hit    = res_hit_reg;
   assign res_t      = res_t_reg;
   assign res_color  = res_color_reg;
   assign res_index  = res_index_reg;

   // Clamp object count, detect final address, and evaluate the nearest-hit candidate.
   always_comb begin
      n_clamp   = (num_objects > MAX_N) ? MAX_N : num_objects;
      n_m1      = n_reg - (ADDR_W+1)'(1);
      last_addr = (addr_reg == n_m1[ADDR_W-1:0]);
      // Memory data lags the address by one cycle: in SCAN it belongs to
      // addr-1, in DRAIN the address has stopped at n-1 so it is addr itself.
      cmp_en    = ((state_reg == SCAN) && d1_reg) || (state_reg == DRAIN);
      cmp_idx   = (state_reg == DRAIN) ? addr_reg : (addr_reg - ADDR_W'(1));
      // Strict less-than lets the lower index win ties.
      cand      = cmp_en && (sph_t != 10'd0) && (sph_t < best_t_reg);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = (n_clamp == '0) ? DONE : SCAN;
         SCAN:    if (last_addr) state_next = DRAIN;
         DRAIN:   state_next = DONE;
         DONE:    if (res_valid_reg && res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ray latch, address counter, nearest-hit tracking and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         init_reg       <= '0;
         dir_reg        <= '0;
         n_reg          <= '0;
         addr_reg       <= '0;
         d1_reg         <= 1'b0;
         best_t_reg     <= 10'h3FF;
         best_color_reg <= BG_COLOR;
         best_index_reg <= '0;
         hit_reg        <= 1'b0;
         res_valid_reg  <= 1'b0;
         res_hit_reg    <= 1'b0;
         res_t_reg      <= 10'h3FF;
         res_color_reg  <= BG_COLOR;
         res_index_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  init_reg       <= ray_init;
                  dir_reg        <= ray_dir;
                  n_reg          <= n_clamp;
                  d1_reg         <= 1'b0;
                  best_t_reg     <= 10'h3FF;
                  best_color_reg <= BG_COLOR;
                  best_index_reg <= '0;
                  hit_reg        <= 1'b0;
                  // An empty scene issues no reads, so the address is left alone.
                  if (n_clamp != '0) addr_reg <= '0;
               end
            end
            SCAN: begin
               d1_reg <= 1'b1;
               if (!last_addr) addr_reg <= addr_reg + ADDR_W'(1);
            end
            DONE: begin
               if (!res_valid_reg) begin
                  res_valid_reg <= 1'b1;
                  res_hit_reg   <= hit_reg;
                  res_t_reg     <= best_t_reg;
                  res_color_reg <= best_color_reg;
                  res_index_reg <= best_index_reg;
               end else if (res_ready) begin
                  res_valid_reg <= 1'b0;
               end
            end
            default: ;
         endcase
         if (cand) begin
            best_t_reg     <= sph_t;
            best_color_reg <= obj_data[49:38];
            best_index_reg <= cmp_idx;
            hit_reg        <= 1'b1;
         end
      end
   end

endmodule
